instr_fetch_unit: RTL and testbench

//  Instruction-fetch responder that produces W_IR_valid and the instruction word for the multi-cycle control FSM.

---
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: one req/ack memory read per fetch window,
// delivered as a single-cycle W_IR_valid pulse with error/timeout/flush handling.
module instr_fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'hE1A00000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic [DATA_W-1:0] ir_data,
  output logic              W_IR_valid,
  output logic              fetch_err,
  output logic [15:0]       fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] ir_q;
  logic              valid_q;
  logic              err_q;
  logic [15:0]       fetch_cnt_q;
  logic [15:0]       fetch_cnt_d;
  logic [7:0]        tmo_q;
  logic [7:0]        tmo_d;
  logic              flushed_q;
  logic              tmo_hit;

  assign fetch_cnt_d = fetch_cnt_q + 16'd1;
  assign tmo_d       = tmo_q + 8'd1;
  assign tmo_hit     = (tmo_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      ir_q        <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      fetch_cnt_q <= '0;
      tmo_q       <= '0;
      flushed_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fetch_en && !flush) begin
            state_q <= REQ;
            addr_q  <= pc;
            req_q   <= 1'b1;
            tmo_q   <= '0;
          end
        end
        REQ: begin
          if (flush) begin
            flushed_q <= 1'b1;
            if (mem_ack) begin
              req_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= DRAIN;
            end
          end else if (mem_ack) begin
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
            if (mem_err) begin
              ir_q  <= NOP_INSTR;
              err_q <= 1'b1;
            end else begin
              ir_q        <= mem_rdata;
              fetch_cnt_q <= fetch_cnt_d;
            end
          end else if (tmo_hit) begin
            // keep the request up so the slave still completes it
            flushed_q <= 1'b0;
            ir_q      <= NOP_INSTR;
            valid_q   <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= DRAIN;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            req_q   <= 1'b0;
            state_q <= flushed_q ? IDLE : DONE;
          end
        end
        DONE: begin
          if (!fetch_en) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign ir_data    = ir_q;
  assign W_IR_valid = valid_q;
  assign fetch_err  = err_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed and random fetches checked
// against a transaction-level outcome model.
module tb_instr_fetch_unit;

  localparam int          TMO = 15;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] pc;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] ir_data;
  logic        W_IR_valid;
  logic        fetch_err;
  logic [15:0] fetch_cnt;

  int          n_asrt = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_en   (fetch_en),
    .pc         (pc),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .ir_data    (ir_data),
    .W_IR_valid (W_IR_valid),
    .fetch_err  (fetch_err),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Outcome model: the pulse lands on REQ cycle min(waits, TMO-1);
  // only an in-time, error-free ack is a good delivery.
  task automatic fetch_txn(input logic [31:0] a,
                           input logic [31:0] d,
                           input int waits,
                           input bit e);
    int          pc_cyc;
    bit          good;
    logic [31:0] exp_ir;
    pc_cyc = (waits < TMO) ? waits : TMO - 1;
    good   = (waits < TMO) && !e;
    exp_ir = good ? d : NOP;
    pc       = a;
    fetch_en = 1'b1;
    tick();
    chk("launch_req", mem_req, 1);
    chk("launch_addr", mem_addr, a);
    chk("launch_valid", W_IR_valid, 0);
    pc = $urandom;
    for (int c = 0; c <= waits; c++) begin
      mem_ack   = (c == waits);
      mem_rdata = (c == waits) ? d : $urandom;
      mem_err   = (c == waits) ? e : 1'($urandom_range(0, 1));
      tick();
      mem_ack = 1'b0;
      mem_err = 1'b0;
      if (c == pc_cyc && good) exp_cnt = exp_cnt + 16'd1;
      chk("valid", W_IR_valid, c == pc_cyc);
      chk("fetch_err", fetch_err, (c == pc_cyc) && !good);
      chk("req", mem_req, c < waits);
      if (c < waits) chk("addr_hold", mem_addr, a);
      if (c == pc_cyc) chk("ir_data", ir_data, exp_ir);
      chk("cnt", fetch_cnt, exp_cnt);
    end
    repeat (2) begin
      tick();
      chk("rearm_req", mem_req, 0);
      chk("rearm_valid", W_IR_valid, 0);
    end
    fetch_en = 1'b0;
    tick();
    chk("release_req", mem_req, 0);
  endtask

  // Flush on REQ cycle fc, ack arrives ad cycles later (0 = same cycle)
  task automatic flush_txn(input logic [31:0] a,
                           input int fc,
                           input int ad);
    pc       = a;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("fl_req", mem_req, 1);
    for (int c = 0; c <= fc + ad; c++) begin
      flush     = (c == fc);
      mem_ack   = (c == fc + ad);
      mem_rdata = $urandom;
      tick();
      flush   = 1'b0;
      mem_ack = 1'b0;
      chk("fl_valid", W_IR_valid, 0);
      chk("fl_err", fetch_err, 0);
      chk("fl_req_c", mem_req, c < fc + ad);
      chk("fl_cnt", fetch_cnt, exp_cnt);
    end
    tick();
    chk("fl_idle_req", mem_req, 0);
    chk("fl_idle_valid", W_IR_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    fetch_en  = 1'b0;
    pc        = '0;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    mem_err   = 1'b0;
    repeat (2) tick();
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ir", ir_data, 0);
    chk("rst_valid", W_IR_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_cnt", fetch_cnt, 0);
    rst_n = 1'b1;
    tick();

    fetch_txn(32'h100, 32'hE3A01005, 0, 1'b0);
    fetch_txn(32'h104, 32'h12345678, 5, 1'b0);
    fetch_txn(32'h108, 32'hDEADBEEF, 2, 1'b1);
    fetch_txn(32'h10C, 32'hCAFEF00D, 20, 1'b0);
    fetch_txn(32'h110, 32'h0BADF00D, TMO - 1, 1'b0);
    fetch_txn(32'h114, 32'h55AA55AA, TMO, 1'b0);

    flush_txn(32'h200, 1, 3);
    fetch_txn(32'h400, 32'hE2811001, 1, 1'b0);
    flush_txn(32'h204, 0, 0);
    fetch_txn(32'h404, 32'hE0800001, 0, 1'b0);

    flush    = 1'b1;
    fetch_en = 1'b1;
    pc       = 32'h300;
    tick();
    chk("flush_idle_block", mem_req, 0);
    flush    = 1'b0;
    fetch_en = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 4) == 0)
        flush_txn($urandom, $urandom_range(0, 10),
                  $urandom_range(0, 4));
      fetch_txn($urandom, $urandom, $urandom_range(0, 20),
                $urandom_range(0, 3) == 0);
    end

    force dut.fetch_cnt_q = 16'hFFFF;
    tick();
    release dut.fetch_cnt_q;
    exp_cnt = 16'hFFFF;
    tick();
    chk("cnt_preset", fetch_cnt, 16'hFFFF);
    fetch_txn(32'h500, 32'hE1A0F00E, 0, 1'b0);
    chk("cnt_wrap", fetch_cnt, 16'h0000);

    pc       = 32'h600;
    fetch_en = 1'b1;
    tick();
    chk("mid_req", mem_req, 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", mem_req, 0);
    chk("async_addr", mem_addr, 0);
    chk("async_ir", ir_data, 0);
    chk("async_valid", W_IR_valid, 0);
    chk("async_err", fetch_err, 0);
    chk("async_cnt", fetch_cnt, 0);
    exp_cnt  = 16'd0;
    fetch_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fetch_txn(32'h700, 32'h600DC0DE, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
